// File: rtl/barrel_shifter_csd_pipe.sv
// Pipelined log-barrel shifter/rotator for two's-complement and CSD (p/n digit-plane) operands.
// One stage per shift-amount bit; a single global advance signal stalls every register together.
module barrel_shifter_csd_pipe #(
  parameter int unsigned W     = 8,
  parameter int unsigned LOG2W = 3,
  parameter int unsigned PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             csd_mode,
  input  logic             dir,
  input  logic             op,
  input  logic             shift_t,
  input  logic [LOG2W-1:0] sel,
  input  logic [W-1:0]     in_p,
  input  logic [W-1:0]     in_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_p,
  output logic [W-1:0]     out_n,
  output logic             out_lost,
  output logic             out_err
);

  localparam int unsigned NS = LOG2W;

  typedef struct packed {
    logic         vld;
    logic [W-1:0] p;
    logic [W-1:0] n;
    logic         lost;
    logic         err;
  } dat_t;

  typedef struct packed {
    logic             dir;
    logic             op;
    logic             ar;
    logic [LOG2W-1:0] sel;
  } ctl_t;

  dat_t [NS:0]   st_d;
  ctl_t [NS-1:0] st_c;
  logic          adv;
  logic [W-1:0]  bad;

  // Whole pipe moves only when the output slot is free or being drained.
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // Illegal CSD digits (both planes set) are flagged and zeroed before shifting.
  assign bad           = csd_mode ? (in_p & in_n) : '0;
  assign st_d[0].vld   = in_valid;
  assign st_d[0].p     = in_p & ~bad;
  assign st_d[0].n     = csd_mode ? (in_n & ~bad) : '0;
  assign st_d[0].lost  = 1'b0;
  assign st_d[0].err   = |bad;
  assign st_c[0].dir   = dir;
  assign st_c[0].op    = op;
  assign st_c[0].ar    = shift_t & ~csd_mode;
  assign st_c[0].sel   = sel;

  for (genvar k = 0; k < NS; k++) begin : g_stg
    localparam int unsigned S = 1 << k;

    dat_t         cd;
    dat_t         nd;
    ctl_t         cc;
    logic [W-1:0] any_nz;
    logic [S-1:0] fill_p;
    logic [S-1:0] fill_n;
    logic         here_lost;

    assign cd = st_d[k];
    assign cc = st_c[k];

    // Move by S digits when sel[k] is set; fill is wrap-around, sign copies, or zeros.
    always_comb begin
      nd        = cd;
      fill_p    = '0;
      fill_n    = '0;
      here_lost = 1'b0;
      any_nz    = cd.p | cd.n;
      if (cc.sel[k]) begin
        if (!cc.dir) begin
          if (cc.op) begin
            fill_p = cd.p[W-1 -: S];
            fill_n = cd.n[W-1 -: S];
          end
          nd.p      = {cd.p[W-S-1:0], fill_p};
          nd.n      = {cd.n[W-S-1:0], fill_n};
          here_lost = |any_nz[W-1 -: S];
        end else begin
          if (cc.op) begin
            fill_p = cd.p[S-1:0];
            fill_n = cd.n[S-1:0];
          end else if (cc.ar) begin
            fill_p = {S{cd.p[W-1]}};
          end
          nd.p      = {fill_p, cd.p[W-1:S]};
          nd.n      = {fill_n, cd.n[W-1:S]};
          here_lost = |any_nz[S-1:0];
        end
      end
      // Rotates and zero-amount beats never report lost digits.
      nd.lost = !cc.op && (cc.sel != '0) && (cd.lost || here_lost);
    end

    if (PIPE != 0 || k == NS - 1) begin : g_reg
      dat_t qd;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          qd <= '0;
        end else if (adv) begin
          qd <= nd;
        end
      end

      assign st_d[k+1] = qd;

      if (k < NS - 1) begin : g_ctl
        ctl_t qc;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            qc <= '0;
          end else if (adv) begin
            qc <= cc;
          end
        end

        assign st_c[k+1] = qc;
      end
    end else begin : g_cmb
      assign st_d[k+1] = nd;
      assign st_c[k+1] = cc;
    end
  end

  assign out_valid = st_d[NS].vld;
  assign out_p     = st_d[NS].p;
  assign out_n     = st_d[NS].n;
  assign out_lost  = st_d[NS].lost;
  assign out_err   = st_d[NS].err;

endmodule

// File: tb/tb_barrel_shifter_csd_pipe.sv
// Scoreboard bench: drives a PIPE=1 and a PIPE=0 instance with identical beats and
// checks both against an arithmetic reference model, including stalls and reset.
module tb_barrel_shifter_csd_pipe;

  typedef struct packed {
    logic [7:0] p;
    logic [7:0] n;
    logic       lost;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       drv_valid = 1'b0;
  logic       drv_csd = 1'b0, drv_dir = 1'b0, drv_op = 1'b0, drv_st = 1'b0;
  logic [2:0] drv_sel = 3'd0;
  logic [7:0] drv_p = 8'h00, drv_n = 8'h00;
  logic       out_ready = 1'b1;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_lost, a_out_err;
  logic [7:0] a_out_p, a_out_n;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_lost, b_out_err;
  logic [7:0] b_out_p, b_out_n;

  int   errors = 0;
  int   checks = 0;
  int   sent = 0;
  int   recv [2];
  logic hold [2];
  exp_t held [2];
  exp_t qa[$];
  exp_t qb[$];
  int   stall_cnt = 0;
  logic rand_bp = 1'b0;

  always #5 clk = ~clk;

  // Both instances accept a beat only together so their scoreboards stay aligned.
  assign a_in_valid = drv_valid & a_in_ready & b_in_ready;
  assign b_in_valid = drv_valid & a_in_ready & b_in_ready;

  barrel_shifter_csd_pipe #(.W(8), .LOG2W(3), .PIPE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .csd_mode(drv_csd), .dir(drv_dir), .op(drv_op), .shift_t(drv_st), .sel(drv_sel),
    .in_p(drv_p), .in_n(drv_n), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_p(a_out_p), .out_n(a_out_n), .out_lost(a_out_lost), .out_err(a_out_err)
  );

  barrel_shifter_csd_pipe #(.W(8), .LOG2W(3), .PIPE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .csd_mode(drv_csd), .dir(drv_dir), .op(drv_op), .shift_t(drv_st), .sel(drv_sel),
    .in_p(drv_p), .in_n(drv_n), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_p(b_out_p), .out_n(b_out_n), .out_lost(b_out_lost), .out_err(b_out_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] p, input logic [7:0] n, input logic lost,
                              input logic err);
    exp_t r;
    r.p = p; r.n = n; r.lost = lost; r.err = err;
    return r;
  endfunction

  // Reference: digit planes shifted with plain operators; rotation via a doubled word.
  function automatic exp_t model(input logic csd, input logic d, input logic o, input logic st,
                                 input logic [2:0] s, input logic [7:0] ip, input logic [7:0] inn);
    logic [7:0]  bad, p, n;
    logic [15:0] pp, nn;
    exp_t        r;
    int          sh;
    sh     = int'(s);
    bad    = csd ? (ip & inn) : 8'h00;
    p      = ip & ~bad;
    n      = csd ? (inn & ~bad) : 8'h00;
    r.err  = |bad;
    r.lost = 1'b0;
    if (o) begin
      pp = {p, p};
      nn = {n, n};
      if (!d) begin
        pp = pp << sh; nn = nn << sh;
        r.p = pp[15:8]; r.n = nn[15:8];
      end else begin
        pp = pp >> sh; nn = nn >> sh;
        r.p = pp[7:0]; r.n = nn[7:0];
      end
    end else if (!d) begin
      r.p    = p << sh;
      r.n    = n << sh;
      r.lost = (((p | n) >> (8 - sh)) != 8'h00);
    end else begin
      r.p    = (!csd && st) ? 8'($signed(p) >>> sh) : (p >> sh);
      r.n    = n >> sh;
      r.lost = (((p | n) & 8'((16'd1 << sh) - 16'd1)) != 8'h00);
    end
    return r;
  endfunction

  task automatic mon(input int w, input logic vld, input logic ir, input exp_t got);
    exp_t e;
    check($sformatf("in_ready_%0d", w), 32'(ir), 32'(!(vld && !out_ready)));
    if (hold[w]) begin
      check($sformatf("hold_valid_%0d", w), 32'(vld), 32'd1);
      check($sformatf("hold_data_%0d", w), 32'(got), 32'(held[w]));
    end
    if (vld && out_ready) begin
      if ((w == 0) ? (qa.size() == 0) : (qb.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat_%0d: got %0h expected no beat", w, got);
      end else begin
        e = (w == 0) ? qa.pop_front() : qb.pop_front();
        check($sformatf("beat_%0d", w), 32'(got), 32'(e));
        recv[w]++;
      end
    end
    hold[w] = vld && !out_ready;
    held[w] = got;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, a_out_valid, a_in_ready, {a_out_p, a_out_n, a_out_lost, a_out_err});
      mon(1, b_out_valid, b_in_ready, {b_out_p, b_out_n, b_out_lost, b_out_err});
    end
  end

  always @(posedge clk) begin
    #1;
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else if (rand_bp) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = 1'b1;
    end
  end

  task automatic send(input logic csd, input logic d, input logic o, input logic st,
                      input logic [2:0] s, input logic [7:0] p, input logic [7:0] n,
                      input exp_t e);
    drv_csd = csd; drv_dir = d; drv_op = o; drv_st = st;
    drv_sel = s; drv_p = p; drv_n = n; drv_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (a_in_ready && b_in_ready) begin
        qa.push_back(e);
        qb.push_back(e);
        sent++;
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got no accept expected accept within 300 cycles");
    drv_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic c, d, o, st;
    logic [2:0] s;
    logic [7:0] p, n;
    c = 1'($urandom); d = 1'($urandom); o = 1'($urandom); st = 1'($urandom);
    s = 3'($urandom); p = 8'($urandom); n = 8'($urandom);
    // Keep illegal CSD digits occasional rather than in almost every beat.
    if (c && $urandom_range(0, 3) != 0) n = n & ~p;
    send(c, d, o, st, s, p, n, model(c, d, o, st, s, p, n));
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && (qa.size() != 0 || qb.size() != 0); t++) @(negedge clk);
    check("drain_a", 32'(qa.size()), 32'd0);
    check("drain_b", 32'(qb.size()), 32'd0);
    check("recv_a", 32'(recv[0]), 32'(sent));
    check("recv_b", 32'(recv[1]), 32'(sent));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int lat_a, lat_b;
    recv[0] = 0; recv[1] = 0; hold[0] = 1'b0; hold[1] = 1'b0;
    held[0] = '0; held[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_a", 32'(a_out_valid), 32'd0);
    check("rst_valid_b", 32'(b_out_valid), 32'd0);
    check("rst_data_a", 32'({a_out_p, a_out_n, a_out_lost, a_out_err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst_a", 32'(a_in_ready), 32'd1);
    check("ready_after_rst_b", 32'(b_in_ready), 32'd1);

    // Latency of a lone beat with the output always ready.
    send(0, 0, 0, 0, 3'd2, 8'h03, 8'h00, mk(8'h0C, 8'h00, 1'b0, 1'b0));
    lat_a = -1; lat_b = -1;
    for (int e = 1; e <= 10 && lat_a < 0; e++) begin
      if (a_out_valid && lat_a < 0) lat_a = e;
      if (b_out_valid && lat_b < 0) lat_b = e;
      if (lat_a < 0) begin
        @(posedge clk);
        #1;
      end
    end
    check("latency_pipe1", 32'(lat_a), 32'd3);
    check("latency_pipe0", 32'(lat_b), 32'd1);

    send(0, 1, 0, 1, 3'd3, 8'h80, 8'h00, mk(8'hF0, 8'h00, 1'b0, 1'b0));
    send(0, 1, 0, 0, 3'd3, 8'h80, 8'h00, mk(8'h10, 8'h00, 1'b0, 1'b0));
    send(1, 1, 0, 0, 3'd1, 8'h41, 8'h10, mk(8'h20, 8'h08, 1'b1, 1'b0));
    send(1, 0, 1, 0, 3'd1, 8'h80, 8'h01, mk(8'h01, 8'h02, 1'b0, 1'b0));
    send(1, 0, 0, 0, 3'd0, 8'h08, 8'h08, mk(8'h00, 8'h00, 1'b0, 1'b1));
    send(1, 0, 0, 0, 3'd1, 8'h0C, 8'h08, mk(8'h08, 8'h00, 1'b0, 1'b1));
    send(0, 0, 0, 0, 3'd7, 8'h03, 8'h00, mk(8'h80, 8'h00, 1'b1, 1'b0));
    send(0, 1, 0, 1, 3'd0, 8'hA5, 8'h00, mk(8'hA5, 8'h00, 1'b0, 1'b0));
    send(0, 1, 1, 1, 3'd4, 8'h0F, 8'hFF, mk(8'hF0, 8'h00, 1'b0, 1'b0));
    send(0, 1, 0, 1, 3'd2, 8'h83, 8'h00, mk(8'hE0, 8'h00, 1'b1, 1'b0));
    send(1, 1, 0, 1, 3'd2, 8'h80, 8'h00, mk(8'h20, 8'h00, 1'b0, 1'b0));
    send(0, 0, 1, 0, 3'd3, 8'h81, 8'h00, mk(8'h0C, 8'h00, 1'b0, 1'b0));
    drain();

    // Six back-to-back beats with a four-cycle output stall in the middle.
    for (int i = 0; i < 6; i++) begin
      if (i == 2) stall_cnt = 4;
      send_rand();
    end
    drain();

    // Asynchronous reset with beats still in flight.
    send_rand();
    send_rand();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid_a", 32'(a_out_valid), 32'd0);
    check("async_rst_valid_b", 32'(b_out_valid), 32'd0);
    check("async_rst_data_a", 32'({a_out_p, a_out_n, a_out_lost, a_out_err}), 32'd0);
    qa.delete(); qb.delete();
    hold[0] = 1'b0; hold[1] = 1'b0;
    sent = 0; recv[0] = 0; recv[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      check("no_stale_a", 32'(a_out_valid), 32'd0);
      check("no_stale_b", 32'(b_out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Randomised sweep with random backpressure and idle gaps.
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      send_rand();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
